// File: rtl/alu_exec_pipe.sv
// alu_exec_pipe: EX-stage ALU with ALUOp/funct decode, registered result, valid/ready handshakes and iterative shift-add MUL
module alu_exec_pipe #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4,
  parameter int MUL_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic [WIDTH-1:0]  src_a,
  input  logic [WIDTH-1:0]  src_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic              zero,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              illegal
);
  localparam int SW = $clog2(WIDTH);
  localparam logic [3:0] OP_MUL = 4'd9;
  typedef enum logic {IDLE, MUL_BUSY} state_t;
  state_t state;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_n, res_c;
  logic [SW-1:0] count, sh;
  logic [3:0] op;
  logic ill;
  logic accept;
  assign sh = src_b[SW-1:0];
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  assign zero = (result == '0);
  assign acc_n = acc + (mplier[0] ? mcand : '0);
  always_comb begin
    op = 4'd0;
    ill = 1'b0;
    case (alu_op)
      2'b01: op = 4'd1;
      2'b11: op = 4'd3;
      2'b10:
        case (funct)
          6'b100000: op = 4'd0;
          6'b100010: op = 4'd1;
          6'b100100: op = 4'd2;
          6'b100101: op = 4'd3;
          6'b100110: op = 4'd4;
          6'b101010: op = 4'd5;
          6'b000000: op = 4'd6;
          6'b000010: op = 4'd7;
          6'b000011: op = 4'd8;
          6'b011000: begin
            op = (MUL_EN != 0) ? OP_MUL : 4'd0;
            ill = (MUL_EN == 0);
          end
          default: ill = 1'b1;
        endcase
      default: op = 4'd0;
    endcase
  end
  always_comb begin
    res_c = src_a + src_b;
    case (op)
      4'd1: res_c = src_a - src_b;
      4'd2: res_c = src_a & src_b;
      4'd3: res_c = src_a | src_b;
      4'd4: res_c = src_a ^ src_b;
      4'd5: res_c = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      4'd6: res_c = src_a << sh;
      4'd7: res_c = src_a >> sh;
      4'd8: res_c = $signed(src_a) >>> sh;
      default: res_c = src_a + src_b;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      alu_ctrl  <= '0;
      illegal   <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      count     <= '0;
    end else if (state == IDLE) begin
      if (accept && op == OP_MUL) begin
        // in_ready guarantees any pending result is being popped on this edge
        state     <= MUL_BUSY;
        out_valid <= 1'b0;
        mcand     <= src_a;
        mplier    <= src_b;
        acc       <= '0;
        count     <= '0;
      end else if (accept) begin
        out_valid <= 1'b1;
        result    <= res_c;
        alu_ctrl  <= CTRL_W'(op);
        illegal   <= ill;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end else begin
      acc    <= acc_n;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (count == SW'(WIDTH-1)) begin
        state     <= IDLE;
        out_valid <= 1'b1;
        result    <= acc_n;
        alu_ctrl  <= CTRL_W'(OP_MUL);
        illegal   <= 1'b0;
        count     <= '0;
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_pipe.sv
// tb_alu_exec_pipe: directed checks of decode, handshake, MUL latency, reset abort and illegal handling
module tb_alu_exec_pipe;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 1;
  logic [1:0] alu_op = 0;
  logic [5:0] funct = 0;
  logic [31:0] src_a = 0, src_b = 0;
  logic in_ready, out_valid, zero, illegal;
  logic [31:0] result;
  logic [3:0] alu_ctrl;
  logic in_ready1, out_valid1, zero1, illegal1;
  logic [31:0] result1;
  logic [3:0] alu_ctrl1;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  alu_exec_pipe #(.WIDTH(32), .CTRL_W(4), .MUL_EN(1)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .alu_ctrl(alu_ctrl), .illegal(illegal));

  alu_exec_pipe #(.WIDTH(32), .CTRL_W(4), .MUL_EN(0)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .alu_op(alu_op), .funct(funct), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid1), .out_ready(out_ready), .result(result1),
    .zero(zero1), .alu_ctrl(alu_ctrl1), .illegal(illegal1));

  task automatic issue(input logic [1:0] o, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1; alu_op = o; funct = f; src_a = a; src_b = b;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 0; #1;
    n_cmp++; if ({out_valid, in_ready, zero, illegal} !== 4'b0110) begin n_bad++; $display("FAIL reset_flags got ov/ir/z/il=%b exp 0110", {out_valid, in_ready, zero, illegal}); end
    n_cmp++; if (result !== 32'h0 || alu_ctrl !== 4'h0) begin n_bad++; $display("FAIL reset_regs got result=%h ctrl=%0d exp 0/0", result, alu_ctrl); end
    out_ready = 0;
    issue(2'b00, 6'h00, 32'd1, 32'd1);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL pre_async_reset got ov=%b exp 1", out_valid); end
    #2 reset = 1; #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL async_reset got ov=%b exp 0", out_valid); end
    #1 reset = 0;
    out_ready = 1;
  endtask

  task automatic test_decode;
    issue(2'b10, 6'b100010, 32'd7, 32'd9);
    n_cmp++; if (result !== 32'hFFFFFFFE || alu_ctrl !== 4'd1 || zero !== 1'b0 || out_valid !== 1'b1) begin n_bad++; $display("FAIL sub got r=%h c=%0d z=%b ov=%b exp fffffffe/1/0/1", result, alu_ctrl, zero, out_valid); end
    issue(2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1);
    n_cmp++; if (result !== 32'd1 || alu_ctrl !== 4'd5) begin n_bad++; $display("FAIL slt got r=%h c=%0d exp 1/5", result, alu_ctrl); end
    issue(2'b01, 6'b111111, 32'd5, 32'd5);
    n_cmp++; if (result !== 32'd0 || zero !== 1'b1 || illegal !== 1'b0 || alu_ctrl !== 4'd1) begin n_bad++; $display("FAIL sub_zero got r=%h z=%b il=%b c=%0d exp 0/1/0/1", result, zero, illegal, alu_ctrl); end
    issue(2'b10, 6'b000000, 32'h0000_0003, 32'h0000_0024);
    n_cmp++; if (result !== 32'h30 || alu_ctrl !== 4'd6) begin n_bad++; $display("FAIL sll got r=%h c=%0d exp 30/6", result, alu_ctrl); end
    issue(2'b10, 6'b000010, 32'h8000_0000, 32'd31);
    n_cmp++; if (result !== 32'd1 || alu_ctrl !== 4'd7) begin n_bad++; $display("FAIL srl got r=%h c=%0d exp 1/7", result, alu_ctrl); end
  endtask

  task automatic test_back_to_back;
    issue(2'b00, 6'h00, 32'd1, 32'd2);
    n_cmp++; if (out_valid !== 1'b1 || result !== 32'd3) begin n_bad++; $display("FAIL b2b_add got ov=%b r=%h exp 1/3", out_valid, result); end
    issue(2'b10, 6'b100100, 32'h0000F0F0, 32'h0000FF00);
    n_cmp++; if (out_valid !== 1'b1 || result !== 32'h0000F000) begin n_bad++; $display("FAIL b2b_and got ov=%b r=%h exp 1/f000", out_valid, result); end
    issue(2'b10, 6'b000011, 32'h80000000, 32'd4);
    n_cmp++; if (out_valid !== 1'b1 || result !== 32'hF8000000 || alu_ctrl !== 4'd8) begin n_bad++; $display("FAIL b2b_sra got ov=%b r=%h c=%0d exp 1/f8000000/8", out_valid, result, alu_ctrl); end
  endtask

  task automatic test_stall;
    issue(2'b10, 6'b100110, 32'hFF, 32'h0F);
    n_cmp++; if (result !== 32'hF0) begin n_bad++; $display("FAIL stall_xor got r=%h exp f0", result); end
    issue(2'b11, 6'h00, 32'h100, 32'h1);
    out_ready = 0;
    in_valid = 1; alu_op = 2'b01; funct = 6'h00; src_a = 32'd10; src_b = 32'd3;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready got %b exp 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1 || result !== 32'h101 || alu_ctrl !== 4'd3 || in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_hold%0d got ov=%b r=%h c=%0d ir=%b exp 1/101/3/0", i, out_valid, result, alu_ctrl, in_ready); end
    end
    out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    n_cmp++; if (out_valid !== 1'b1 || result !== 32'd7) begin n_bad++; $display("FAIL stall_resume got ov=%b r=%h exp 1/7", out_valid, result); end
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_r, input string name);
    int lat = 0, busy_ready = 0;
    issue(2'b10, 6'b011000, a, b);
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      if (in_ready !== 1'b0) busy_ready++;
      @(posedge clk); #1;
      if (out_valid === 1'b1) lat = k;
    end
    n_cmp++; if (lat !== 32 || busy_ready !== 0) begin n_bad++; $display("FAIL %s_latency got lat=%0d ready_cycles=%0d exp 32/0", name, lat, busy_ready); end
    n_cmp++; if (result !== exp_r || alu_ctrl !== 4'd9 || illegal !== 1'b0) begin n_bad++; $display("FAIL %s_result got r=%h c=%0d il=%b exp %h/9/0", name, result, alu_ctrl, illegal, exp_r); end
  endtask

  task automatic test_mul;
    run_mul(32'd123, 32'd456, 32'd56088, "mul_small");
    run_mul(32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, "mul_wrap");
  endtask

  task automatic test_mul_reset;
    logic seen = 0;
    issue(2'b10, 6'b011000, 32'd3, 32'd3);
    repeat (10) @(posedge clk);
    #1 reset = 1; #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL mul_abort got ov=%b ir=%b exp 0/1", out_valid, in_ready); end
    reset = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL mul_abort_no_result got seen=%b exp 0", seen); end
    issue(2'b00, 6'h00, 32'd5, 32'd5);
    n_cmp++; if (out_valid !== 1'b1 || result !== 32'd10) begin n_bad++; $display("FAIL add_after_abort got ov=%b r=%h exp 1/a", out_valid, result); end
  endtask

  task automatic test_illegal;
    issue(2'b10, 6'b111111, 32'd3, 32'd4);
    n_cmp++; if (result !== 32'd7 || illegal !== 1'b1 || alu_ctrl !== 4'd0) begin n_bad++; $display("FAIL illegal_funct got r=%h il=%b c=%0d exp 7/1/0", result, illegal, alu_ctrl); end
    issue(2'b10, 6'b011000, 32'd6, 32'd7);
    n_cmp++; if (out_valid1 !== 1'b1 || result1 !== 32'd13 || illegal1 !== 1'b1 || alu_ctrl1 !== 4'd0) begin n_bad++; $display("FAIL mul_disabled got ov=%b r=%h il=%b c=%0d exp 1/d/1/0", out_valid1, result1, illegal1, alu_ctrl1); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL mul_enabled_busy got ir=%b exp 0", in_ready); end
  endtask

  initial begin
    test_reset;
    test_decode;
    test_back_to_back;
    test_stall;
    test_mul;
    test_mul_reset;
    test_illegal;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
